// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: op codes, FSM states, default width.
// SEQ_ALU_DIV_EN selects whether DIVU/REMU run on the iterative engine.
package alu_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_SLL   = 4'b0010,
        ALU_SLT   = 4'b0011,
        ALU_SLTU  = 4'b0100,
        ALU_XOR   = 4'b0101,
        ALU_SRL   = 4'b0110,
        ALU_SRA   = 4'b0111,
        ALU_OR    = 4'b1000,
        ALU_AND   = 4'b1001,
        ALU_PASSB = 4'b1010,
        ALU_MUL   = 4'b1011,
        ALU_MULHU = 4'b1100,
        ALU_DIVU  = 4'b1101,
        ALU_REMU  = 4'b1110,
        ALU_RSVD  = 4'b1111
    } aluop_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // Ops that go through the bit-serial engine instead of the one-cycle mux
    function automatic logic is_iter_op(aluop_e op);
`ifdef SEQ_ALU_DIV_EN
        return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
`else
        return (op == ALU_MUL) || (op == ALU_MULHU);
`endif
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Bit-serial unsigned multiply (shift-add) and, with SEQ_ALU_DIV_EN, restoring divide.
// Accumulator holds {hi, lo}: product for multiply, {remainder, quotient} for divide.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  aluop_e          op,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic            done_c,
    output logic [XLEN-1:0] res_c
);

    localparam int unsigned CNTW = $clog2(XLEN) + 1;

    logic [2*XLEN-1:0] acc_q, acc_d, step_c;
    logic [XLEN-1:0]   opnd_q, opnd_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              hi_sel_q, hi_sel_d;
    logic [XLEN:0]     sum_c;
`ifdef SEQ_ALU_DIV_EN
    logic              is_div_q, is_div_d;
    logic [XLEN:0]     rsh_c, diff_c;
`endif

    // One iteration: multiplier LSB first, or dividend MSB first
    always_comb begin
        sum_c  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        step_c = {sum_c, acc_q[XLEN-1:1]};
`ifdef SEQ_ALU_DIV_EN
        rsh_c  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff_c = rsh_c - {1'b0, opnd_q};
        if (is_div_q) begin
            step_c = diff_c[XLEN] ? {rsh_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                  : {diff_c[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end
`endif
    end

    always_comb begin
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        hi_sel_d = hi_sel_q;
`ifdef SEQ_ALU_DIV_EN
        is_div_d = is_div_q;
`endif
        if (start) begin
            acc_d    = {XLEN'(0), opa};
            opnd_d   = opb;
            cnt_d    = CNTW'(XLEN);
`ifdef SEQ_ALU_DIV_EN
            hi_sel_d = (op == ALU_MULHU) || (op == ALU_REMU);
            is_div_d = (op == ALU_DIVU) || (op == ALU_REMU);
`else
            hi_sel_d = (op == ALU_MULHU);
`endif
        end else if (cnt_q != '0) begin
            acc_d = step_c;
            cnt_d = cnt_q - CNTW'(1);
        end
    end

    // Final step is in flight when the counter reads 1; expose its result directly
    assign done_c = (cnt_q == CNTW'(1));
    assign res_c  = hi_sel_q ? step_c[2*XLEN-1:XLEN] : step_c[XLEN-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            hi_sel_q <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            is_div_q <= 1'b0;
`endif
        end else begin
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            hi_sel_q <= hi_sel_d;
`ifdef SEQ_ALU_DIV_EN
            is_div_q <= is_div_d;
`endif
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked execute-stage ALU: one-cycle base ops plus iterative MUL/MULHU
// (and DIVU/REMU when SEQ_ALU_DIV_EN is defined, otherwise those codes read as reserved).
module seq_alu
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      aluop,
    input  logic [XLEN-1:0] oprand_a,
    input  logic [XLEN-1:0] oprand_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            result_zero,
    output logic            busy
);

    localparam int unsigned SHW = $clog2(XLEN);

    state_e          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            zero_q, zero_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;
    logic            accept_c, start_c, iter_done_c;
    logic [XLEN-1:0] iter_res_c, base_res_c;
    aluop_e          op_c;

    function automatic logic [XLEN-1:0] base_op(aluop_e op, logic [XLEN-1:0] a,
                                                logic [XLEN-1:0] b);
        logic [SHW-1:0] sh;
        sh = b[SHW-1:0];
        case (op)
            ALU_ADD:   return a + b;
            ALU_SUB:   return a - b;
            ALU_SLL:   return a << sh;
            ALU_SLT:   return XLEN'($signed(a) < $signed(b));
            ALU_SLTU:  return XLEN'(a < b);
            ALU_XOR:   return a ^ b;
            ALU_SRL:   return a >> sh;
            ALU_SRA:   return XLEN'($unsigned($signed(a) >>> sh));
            ALU_OR:    return a | b;
            ALU_AND:   return a & b;
            ALU_PASSB: return b;
            default:   return '0;
        endcase
    endfunction

    assign op_c       = aluop_e'(aluop);
    assign in_ready   = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept_c   = in_valid && in_ready;
    assign base_res_c = base_op(op_c, oprand_a, oprand_b);

    alu_iter_muldiv #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_c),
        .op     (op_c),
        .opa    (oprand_a),
        .opb    (oprand_b),
        .done_c (iter_done_c),
        .res_c  (iter_res_c)
    );

    // DONE shares the IDLE accept path so base ops stream at one per cycle
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        zero_d      = zero_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;
        start_c     = 1'b0;
        case (state_q)
            BUSY: begin
                if (iter_done_c) begin
                    result_d    = iter_res_c;
                    zero_d      = (iter_res_c == '0);
                    out_valid_d = 1'b1;
                    busy_d      = 1'b0;
                    state_d     = DONE;
                end
            end
            default: begin
                if ((state_q == DONE) && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
                if (accept_c) begin
                    if (is_iter_op(op_c)) begin
                        start_c     = 1'b1;
                        busy_d      = 1'b1;
                        out_valid_d = 1'b0;
                        state_d     = BUSY;
                    end else begin
                        result_d    = base_res_c;
                        zero_d      = (base_res_c == '0);
                        out_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            result_q    <= '0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign result      = result_q;
    assign result_zero = zero_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: directed cases plus randomized ops against a reference model.
module tb_seq_alu;

    localparam int unsigned XLEN = 32;
`ifdef SEQ_ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_SLT = 4'h3, OP_SLTU = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5, OP_SRA = 4'h7, OP_AND = 4'h9;
    localparam logic [3:0] OP_MUL = 4'hB, OP_MULHU = 4'hC, OP_DIVU = 4'hD, OP_REMU = 4'hE;

    logic            clk, rst_n, in_valid, in_ready, out_valid, out_ready, result_zero, busy;
    logic [3:0]      aluop;
    logic [XLEN-1:0] oprand_a, oprand_b, result;

    typedef struct {
        logic [XLEN-1:0] res;
        int              lat;
        int              acc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   seen_cur = 1'b0;
    bit   rand_bp = 1'b0;
    bit   ready_force = 1'b1;

    seq_alu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .aluop       (aluop),
        .oprand_a    (oprand_a),
        .oprand_b    (oprand_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .result_zero (result_zero),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: plain arithmetic on wide integers
    function automatic logic [XLEN-1:0] model(input logic [3:0] op, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic [2*XLEN-1:0] prod, sext;
        int unsigned       sh;
        sh   = b % XLEN;
        prod = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        sext = {{XLEN{a[XLEN-1]}}, a} >> sh;
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a << sh;
            4'h3: return ($signed(a) < $signed(b)) ? 1 : 0;
            4'h4: return (a < b) ? 1 : 0;
            4'h5: return a ^ b;
            4'h6: return a >> sh;
            4'h7: return sext[XLEN-1:0];
            4'h8: return a | b;
            4'h9: return a & b;
            4'hA: return b;
            4'hB: return prod[XLEN-1:0];
            4'hC: return prod[2*XLEN-1:XLEN];
            4'hD: return !DIV_EN ? 0 : (b == 0) ? {XLEN{1'b1}} : a / b;
            4'hE: return !DIV_EN ? 0 : (b == 0) ? a : a % b;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_lat(input logic [3:0] op);
        if (op == OP_MUL || op == OP_MULHU) return XLEN + 1;
        if ((op == OP_DIVU || op == OP_REMU) && DIV_EN) return XLEN + 1;
        return 1;
    endfunction

    // Consumer side: random or forced backpressure, changed well away from both edges
    always @(posedge clk) begin
        #2;
        out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : ready_force;
    end

    // Monitor: latency on first presentation, value every presented cycle, pop on transfer
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) begin
                chk("busy_in_ready", in_ready, 0);
                chk("busy_out_valid", out_valid, 0);
            end
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL stray_out_valid: got result %h with nothing expected (cycle %0d)", result, cyc);
                end else begin
                    if (!seen_cur) begin
                        chk("latency", cyc - sb_q[0].acc + 1, sb_q[0].lat);
                        seen_cur = 1'b1;
                    end
                    chk("result", result, sb_q[0].res);
                    chk("result_zero", result_zero, (sb_q[0].res == 0) ? 1 : 0);
                    if (out_ready) begin
                        void'(sb_q.pop_front());
                        seen_cur = 1'b0;
                    end
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that took the request
    task automatic issue(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [XLEN-1:0] exp_res, output int acc);
        in_valid = 1'b1;
        aluop    = op;
        oprand_a = a;
        oprand_b = b;
        acc      = -1;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc + 1;
                break;
            end
        end
        if (acc < 0) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: op %h not accepted within 200 cycles", op);
        end else begin
            sb_q.push_back('{exp_res, exp_lat(op), acc});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        aluop    = 4'($urandom);
        oprand_a = $urandom;
        oprand_b = $urandom;
    endtask

    task automatic drain();
        for (int w = 0; w < 2000 && sb_q.size() != 0; w++) @(posedge clk);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb_q.size());
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_result_zero"}, result_zero, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    function automatic logic [XLEN-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return {XLEN{1'b1}};
            2:       return {1'b1, {(XLEN-1){1'b0}}};
            3:       return $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, a1, a2, a3, a4, c0;
        logic [3:0]      op;
        logic [XLEN-1:0] a, b;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        aluop     = '0;
        oprand_a  = '0;
        oprand_b  = '0;
        out_ready = 1'b1;
        #3;
        rst_chk("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        issue(OP_ADD, 5, 3, 8, acc);
        issue(OP_SUB, 3, 5, 32'hFFFF_FFFE, acc);
        issue(OP_SRA, 32'h8000_0000, 4, 32'hF800_0000, acc);
        issue(OP_MUL, 7, 6, 42, acc);
        chk("busy_after_mul_accept", busy, 1);
        issue(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, acc);
        chk("busy_after_mulhu_accept", busy, 1);
        issue(OP_DIVU, 100, 7, DIV_EN ? 14 : 0, acc);
        issue(OP_REMU, 100, 7, DIV_EN ? 2 : 0, acc);
        issue(OP_DIVU, 5, 0, DIV_EN ? 32'hFFFF_FFFF : 0, acc);
        issue(OP_REMU, 5, 0, DIV_EN ? 5 : 0, acc);
        drain();

        // Backpressure: result held, new request taken on the releasing edge
        ready_force = 1'b0;
        issue(OP_ADD, 1, 1, 2, acc);
        in_valid = 1'b1;
        aluop    = OP_XOR;
        oprand_a = 32'h0000_F0F0;
        oprand_b = 32'h0000_0FF0;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_result", result, 2);
        end
        @(posedge clk);
        #1;
        ready_force = 1'b1;
        c0 = cyc;
        issue(OP_XOR, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00, acc);
        chk("bp_same_edge_accept", acc, c0 + 1);
        drain();

        // Streaming base ops
        issue(OP_SLT, 32'hFFFF_FFFF, 1, 1, a1);
        issue(OP_SLTU, 32'hFFFF_FFFF, 1, 0, a2);
        issue(OP_ADD, 32'h10, 32'h20, 32'h30, a3);
        issue(OP_AND, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00, a4);
        chk("stream_accept_1", a2, a1 + 1);
        chk("stream_accept_2", a3, a2 + 1);
        chk("stream_accept_3", a4, a3 + 1);
        drain();

        // Reset in the middle of a multiply
        issue(OP_MUL, 123, 456, model(OP_MUL, 123, 456), acc);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb_q.delete();
        seen_cur = 1'b0;
        #1;
        rst_chk("midop_reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin
            @(negedge clk);
            chk("post_reset_no_valid", out_valid, 0);
        end
        @(posedge clk);
        #1;
        issue(OP_ADD, 2, 2, 4, acc);
        drain();

        // Randomized ops under random backpressure
        rand_bp = 1'b1;
        for (int i = 0; i < 300; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = pick();
            b  = pick();
            issue(op, a, b, model(op, a, b), acc);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_bp = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked ALU for the next pipeline revision.
- Executes the existing base op set (add through pass-B) in one cycle.
- Adds iterative unsigned multiply and, optionally, divide/remainder, using a bit-serial engine.
- Sits in the execute stage. Accepts operands over valid/ready and returns a registered result over valid/ready, so the pipeline stalls while a multi-cycle op runs.

Parameters:
- XLEN, 32: operand/result width, power of two, at least 8.
- SHW, $clog2(XLEN): shift-amount width; derived, do not override.
- CNTW, $clog2(XLEN)+1: iteration counter width; derived.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand/op request valid.
- in_ready  out  1  block can accept a request this cycle.
- aluop  in  4  operation code (aluop_e).
- oprand_a  in  XLEN  operand A.
- oprand_b  in  XLEN  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  registered result.
- result_zero  out  1  result == 0; registered alongside result.
- busy  out  1  iterative op in progress.

Behaviour:
- Reset: async assert of rst_n, with no clock, forces:
  - state=IDLE, out_valid=0, result=0, result_zero=0, busy=0, counter=0, and all engine registers cleared.
  - in_ready=1 after reset releases. A reset mid-operation aborts the op with no output.
- Transfer rules:
  - A request transfers when in_valid&&in_ready.
  - A result transfers when out_valid&&out_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready).
- States:
  - IDLE:
    - On transfer of a base op (0000-1010) or reserved op (1111): compute combinationally, register result, go to DONE. Latency 1.
    - On transfer of MUL/MULHU/DIVU/REMU: latch operands, clear accumulator, counter=XLEN, go to BUSY.
  - BUSY:
    - busy=1, in_ready=0.
    - One bit per cycle. Multiply is shift-add, LSB of multiplier first. Divide is restoring, MSB of dividend first.
    - counter decrements each cycle. At counter==1, register the final result and go to DONE.
    - Transfer to out_valid takes exactly XLEN+1 edges.
  - DONE:
    - out_valid=1. result is held stable until accepted.
    - On out_ready with no new request: go to IDLE.
    - On out_ready with a simultaneous new request: accept it that same edge and behave as IDLE-accept. Back-to-back base ops therefore give 1/cycle throughput.
- Ops. Shift amounts use oprand_b[SHW-1:0].
  - 0000 ADD, 0001 SUB, 0010 SLL.
  - 0011 SLT signed, 0100 SLTU.
  - 0101 XOR, 0110 SRL.
  - 0111 SRA: always arithmetic; sign-fills from bit XLEN-1.
  - 1000 OR, 1001 AND, 1010 PASSB.
  - 1011 MUL: low XLEN bits of the unsigned product.
  - 1100 MULHU: high XLEN bits of the unsigned product.
  - 1101 DIVU, 1110 REMU.
  - 1111 reserved: result 0.
- Arithmetic is modulo 2^XLEN; no overflow flag. The product accumulator is 2*XLEN wide.
- Divide by zero: DIVU = all ones, REMU = oprand_a, still XLEN+1 latency.
- Operand inputs are ignored outside the transfer cycle; the engine uses latched copies.

Optional Feature:
- SEQ_ALU_DIV_EN defined: DIVU/REMU are implemented as above.
- Undefined: the divider logic is removed. 1101/1110 behave as reserved (result 0, latency 1). MUL/MULHU are unaffected.

Decomposition:
- Package alu_pkg holds:
  - aluop_e, a 4-bit enum with all 16 codes.
  - state_e (IDLE, BUSY, DONE).
  - Default XLEN localparam.
- One sub-module, alu_iter_muldiv: the bit-serial multiply/divide datapath with start/done.
- seq_alu keeps the FSM, the handshake, and the single-cycle op mux.

Test Plan:
- Reset then ADD 5+3, out_ready=1: out_valid at edge 1 after accept, result 8. Then SUB 3-5 gives 0xFFFFFFFE. SRA 0x80000000 by 4 gives 0xF8000000.
- MUL 7*6, then MULHU 0xFFFFFFFF*0xFFFFFFFF: first result 42; second 0xFFFFFFFE. Each out_valid exactly 33 edges after accept, busy=1 throughout, in_ready=0.
- With macro: DIVU 100/7 gives 14, REMU 100/7 gives 2. DIVU 5/0 gives 0xFFFFFFFF, REMU 5/0 gives 5. All at 33-edge latency. Without macro: DIVU gives 0 with 1-edge latency.
- Backpressure: ADD 1+1 with out_ready=0 for 5 cycles. result stays 2, in_ready=0; then out_ready=1 with a new XOR request accepted the same edge.
- Streaming: 4 back-to-back base ops with out_ready=1 produce 4 results on consecutive cycles. SLT 0xFFFFFFFF,1 gives 1; SLTU on the same operands gives 0.
- Reset mid-MUL at cycle 10: outputs clear immediately, no stray out_valid. The next ADD 2+2 gives 4 normally.
